pim_bank_mem: RTL

Memory-side responder for the PIM dot-product engine. It serves the engine's two read ports (vector A and vector B) and its result write-back port. It also arbitrates a single-beat host access port used to preload vectors and fetch results. It sits between the PIM MAC engine and the bank storage, holds the storage array itself, and keeps saturating access statistics.

---
 rtl/pim_pkg.sv | 22 ++
 rtl/pim_sat_counter.sv | 27 ++
 rtl/pim_bank_mem.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pim_pkg.sv
// Shared types and helpers for the PIM bank memory and its MAC engine.
package pim_pkg;

    localparam int unsigned PIM_ADDR_W = 16;
    localparam int unsigned PIM_DATA_W = 32;
    localparam int unsigned SAT_MAX_W  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PIM    = 2'd1,
        COMMIT = 2'd2
    } own_e;

    // Increments v, holding at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [SAT_MAX_W-1:0] lim;
        lim = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
        return (v == lim) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/pim_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module pim_sat_counter
    import pim_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) cnt_d = CNT_W'(sat_inc(SAT_MAX_W'(cnt_q), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pim_bank_mem.sv
// Bank storage serving the PIM engine's two read ports and result write-back,
// with a lower-priority single-beat host port and saturating access statistics.
module pim_bank_mem
    import pim_pkg::*;
#(
    parameter int unsigned ADDR_W = PIM_ADDR_W,
    parameter int unsigned DATA_W = PIM_DATA_W,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pim_busy,
    input  logic [ADDR_W-1:0] pim_rd_addr_a,
    input  logic              pim_rd_en_a,
    output logic [DATA_W-1:0] pim_rd_data_a,
    input  logic [ADDR_W-1:0] pim_rd_addr_b,
    input  logic              pim_rd_en_b,
    output logic [DATA_W-1:0] pim_rd_data_b,
    input  logic [ADDR_W-1:0] pim_wr_addr,
    input  logic              pim_wr_en,
    input  logic [DATA_W-1:0] pim_wr_data,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [CNT_W-1:0]  pim_rd_cnt,
    output logic [CNT_W-1:0]  host_acc_cnt,
    output logic [CNT_W-1:0]  host_stall_cnt,
    output logic              addr_err
);

    localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    own_e              own_q, own_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic a_ok, b_ok, w_ok, h_ok;
    logic host_wr, host_rd, commit, err_set;

    assign a_ok = ({1'b0, pim_rd_addr_a} < DEPTH_L);
    assign b_ok = ({1'b0, pim_rd_addr_b} < DEPTH_L);
    assign w_ok = ({1'b0, pim_wr_addr}   < DEPTH_L);
    assign h_ok = ({1'b0, host_addr}     < DEPTH_L);

    always_comb begin
        own_d = own_q;
        case (own_q)
            IDLE:    if (pim_busy)  own_d = PIM;
            PIM:     if (!pim_busy) own_d = COMMIT;
            COMMIT:  own_d = IDLE;
            default: own_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) own_q <= IDLE;
        else        own_q <= own_d;
    end

    // Host is refused in the very cycle pim_busy rises, before own leaves IDLE.
    assign host_gnt = host_req & rst_n & (own_q == IDLE) & ~pim_busy;
    assign host_wr  = host_gnt & host_we & h_ok;
    assign host_rd  = host_gnt & ~host_we;
    assign commit   = rst_n & (own_q == COMMIT) & pim_wr_en;

    assign pim_rd_data_a = a_ok ? mem[pim_rd_addr_a[IDX_W-1:0]] : '0;
    assign pim_rd_data_b = b_ok ? mem[pim_rd_addr_b[IDX_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (host_wr)            mem[host_addr[IDX_W-1:0]]   <= host_wdata;
        else if (commit & w_ok) mem[pim_wr_addr[IDX_W-1:0]] <= pim_wr_data;
    end

    assign err_set = (host_gnt & ~h_ok) | (pim_rd_en_a & ~a_ok) |
                     (pim_rd_en_b & ~b_ok) | (commit & ~w_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= host_rd;
            if (host_rd) rdata_q <= h_ok ? mem[host_addr[IDX_W-1:0]] : '0;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign addr_err    = err_q;

    pim_sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   ((own_q == PIM) & (pim_rd_en_a | pim_rd_en_b)),
        .count_o (pim_rd_cnt)
    );

    pim_sat_counter #(.CNT_W(CNT_W)) u_acc_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (host_gnt),
        .count_o (host_acc_cnt)
    );

    pim_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (host_req & ~host_gnt),
        .count_o (host_stall_cnt)
    );

endmodule
